// File: rtl/rf_host_bridge_pkg.sv
// Shared types and constants for the register-file host bridge.
package rf_host_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 16;
   localparam int unsigned WAIT_CNT_W      = 8;

   typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/rf_host_bridge.sv
// Bridges a valid/ready host request/response channel onto a register-file
// software port, with a per-access completion timeout.
module rf_host_bridge
   import rf_host_bridge_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ADDR_MSB = 8,
   parameter int unsigned ADDR_LSB = 3,
   parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_MSB:ADDR_LSB] req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_error,
   output logic                   rsp_timeout,
   output logic [ADDR_MSB:ADDR_LSB] address,
   output logic                   read_en,
   output logic                   write_en,
   output logic [DATA_W-1:0]      write_data,
   input  logic [DATA_W-1:0]      read_data,
   input  logic                   invalid_address,
   input  logic                   access_complete
);

   state_e                    state_q;
   logic                      is_write_q;
   logic [ADDR_MSB:ADDR_LSB]  addr_q;
   logic [DATA_W-1:0]         wdata_q;
   logic                      read_en_q;
   logic                      write_en_q;
   logic                      rsp_valid_q;
   logic [DATA_W-1:0]         rsp_rdata_q;
   logic                      rsp_error_q;
   logic                      rsp_timeout_q;
   wait_cnt_t                 wait_cnt_q;
   wait_cnt_t                 wait_cnt_d;
   logic                      timeout_hit;

   assign wait_cnt_d  = wait_cnt_q + wait_cnt_t'(1);
   assign timeout_hit = (wait_cnt_d == wait_cnt_t'(TIMEOUT));

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q       <= ST_IDLE;
         is_write_q    <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         read_en_q     <= 1'b0;
         write_en_q    <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_error_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  is_write_q <= req_write;
                  addr_q     <= req_addr;
                  wdata_q    <= req_write ? req_wdata : '0;
                  read_en_q  <= ~req_write;
                  write_en_q <= req_write;
                  wait_cnt_q <= '0;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE, ST_WAIT: begin
               // Strobe lasts only the ISSUE cycle; completion beats the timeout.
               read_en_q  <= 1'b0;
               write_en_q <= 1'b0;
               if (access_complete) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_error_q   <= invalid_address;
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= (!is_write_q && !invalid_address) ? read_data : '0;
                  state_q       <= ST_RESP;
               end else if (timeout_hit) begin
                  wait_cnt_q    <= wait_cnt_d;
                  rsp_valid_q   <= 1'b1;
                  rsp_error_q   <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  rsp_rdata_q   <= '0;
                  state_q       <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
                  state_q    <= ST_WAIT;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q   <= 1'b0;
                  rsp_rdata_q   <= '0;
                  rsp_error_q   <= 1'b0;
                  rsp_timeout_q <= 1'b0;
                  state_q       <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_timeout = rsp_timeout_q;
   assign address     = addr_q;
   assign read_en     = read_en_q;
   assign write_en    = write_en_q;
   assign write_data  = wdata_q;

endmodule

// File: tb/tb_rf_host_bridge.sv
// Randomised scoreboard bench for rf_host_bridge with a behavioural register
// file on the software port and a response sink with programmable stalls.
module tb_rf_host_bridge;

   localparam int unsigned DATA_W   = 64;
   localparam int unsigned ADDR_MSB = 8;
   localparam int unsigned ADDR_LSB = 3;
   localparam int unsigned TIMEOUT  = 16;
   localparam int unsigned AW       = ADDR_MSB - ADDR_LSB + 1;
   localparam int          NO_CPL   = 1000;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              error;
      logic              timeout;
      int                first_cyc;
   } exp_t;

   logic                    clk;
   logic                    res;
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDR_MSB:ADDR_LSB] req_addr;
   logic [DATA_W-1:0]       req_wdata;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_W-1:0]       rsp_rdata;
   logic                    rsp_error;
   logic                    rsp_timeout;
   logic [ADDR_MSB:ADDR_LSB] address;
   logic                    read_en;
   logic                    write_en;
   logic [DATA_W-1:0]       write_data;
   logic [DATA_W-1:0]       read_data;
   logic                    invalid_address;
   logic                    access_complete;

   exp_t              exp_q[$];
   int                n_checks = 0;
   int                n_fail   = 0;
   int                cyc      = 0;
   logic [DATA_W-1:0] ref_mem [0:(1<<AW)-1];
   logic [DATA_W-1:0] rf_mem  [0:(1<<AW)-1];

   // Current transaction as seen by the register-file model and the sink.
   bit                exp_write  = 1'b0;
   logic [AW-1:0]     exp_addr   = '0;
   logic [DATA_W-1:0] exp_wdata  = '0;
   int                rf_delay   = NO_CPL;
   bit                rf_invalid = 1'b0;
   int                rsp_stall  = 0;

   rf_host_bridge #(
      .DATA_W   (DATA_W),
      .ADDR_MSB (ADDR_MSB),
      .ADDR_LSB (ADDR_LSB),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk             (clk),
      .res             (res),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_rdata       (rsp_rdata),
      .rsp_error       (rsp_error),
      .rsp_timeout     (rsp_timeout),
      .address         (address),
      .read_en         (read_en),
      .write_en        (write_en),
      .write_data      (write_data),
      .read_data       (read_data),
      .invalid_address (invalid_address),
      .access_complete (access_complete)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   task automatic fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event occurred but was not allowed", nm);
   endtask

   // Register file: completes rf_delay cycles after the strobe, injects stray completes when idle.
   initial begin : rf_model
      bit active;
      int cnt;
      active = 1'b0;
      cnt    = 0;
      access_complete = 1'b0;
      invalid_address = 1'b0;
      read_data       = '0;
      forever begin
         @(negedge clk);
         access_complete = 1'b0;
         invalid_address = 1'b0;
         read_data       = '0;
         if (res) begin
            active = 1'b0;
            continue;
         end
         if (!active && (read_en || write_en)) begin
            check("issue_strobe", 64'({read_en, write_en}), 64'({~exp_write, exp_write}));
            check("issue_addr", 64'(address), 64'(exp_addr));
            check("issue_wdata", write_data, exp_write ? exp_wdata : 64'd0);
            if (write_en && !rf_invalid) rf_mem[address] = write_data;
            active = 1'b1;
            cnt    = 0;
         end else if (active) begin
            cnt++;
            if (cnt <= int'(TIMEOUT) - 1) begin
               check("wait_strobe", 64'({read_en, write_en}), 64'd0);
               check("wait_addr_hold", 64'(address), 64'(exp_addr));
               check("wait_wdata_hold", write_data, exp_write ? exp_wdata : 64'd0);
            end else begin
               active = 1'b0;
            end
         end
         if (active && cnt == rf_delay) begin
            access_complete = 1'b1;
            invalid_address = rf_invalid;
            read_data       = rf_invalid ? {$urandom, $urandom} : rf_mem[address];
            active          = 1'b0;
         end else if (!active && $urandom_range(0, 3) == 0) begin
            access_complete = 1'b1;
            invalid_address = 1'($urandom_range(0, 1));
            read_data       = {$urandom, $urandom};
         end
      end
   end

   // Response sink: holds rsp_ready low for rsp_stall cycles of each response.
   initial begin : sink
      int hold;
      hold      = 0;
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rsp_valid && !res) begin
            rsp_ready = (hold >= rsp_stall);
            hold++;
         end else begin
            rsp_ready = 1'b0;
            hold      = 0;
         end
      end
   end

   initial begin : monitor
      bit                in_rsp;
      exp_t              e;
      logic [DATA_W-1:0] p_rdata;
      logic              p_err;
      logic              p_to;
      in_rsp  = 1'b0;
      p_rdata = '0;
      p_err   = 1'b0;
      p_to    = 1'b0;
      forever begin
         @(negedge clk);
         if (res) begin
            in_rsp = 1'b0;
            continue;
         end
         if (rsp_valid) begin
            check("req_ready_in_resp", 64'(req_ready), 64'd0);
            if (!in_rsp) begin
               if (exp_q.size() == 0) fail("unexpected_rsp");
               else check("rsp_latency", 64'(cyc), 64'(exp_q[0].first_cyc));
               in_rsp = 1'b1;
            end else begin
               check("rsp_rdata_stable", rsp_rdata, p_rdata);
               check("rsp_error_stable", 64'(rsp_error), 64'(p_err));
               check("rsp_timeout_stable", 64'(rsp_timeout), 64'(p_to));
            end
            p_rdata = rsp_rdata;
            p_err   = rsp_error;
            p_to    = rsp_timeout;
            if (rsp_ready) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("rsp_rdata", rsp_rdata, e.rdata);
                  check("rsp_error", 64'(rsp_error), 64'(e.error));
                  check("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
               end
               in_rsp = 1'b0;
            end
         end
      end
   end

   // Issues one request from a negedge; the reference outcome comes from the
   // programmed completion delay, the invalid flag and the reference memory.
   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DATA_W-1:0] wd,
                        input int dly, input bit inv, input int stall, input bit expect_rsp);
      exp_t e;
      int   guard;
      bit   done;
      guard = 0;
      while (!req_ready && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         fail("req_ready_wait");
         return;
      end
      done       = (dly < int'(TIMEOUT));
      exp_write  = wr;
      exp_addr   = a;
      exp_wdata  = wd;
      rf_delay   = dly;
      rf_invalid = inv;
      rsp_stall  = stall;
      e.first_cyc = done ? cyc + 2 + dly : cyc + 1 + int'(TIMEOUT);
      e.error     = done ? inv : 1'b1;
      e.timeout   = !done;
      e.rdata     = (done && !wr && !inv) ? ref_mem[a] : '0;
      if (wr && !inv) ref_mem[a] = wd;
      if (expect_rsp) exp_q.push_back(e);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      @(negedge clk);
      check("req_ready_busy", 64'(req_ready), 64'd0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int               r;
      int               dly;
      int               guard;
      logic [DATA_W-1:0] v;
      res       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < (1 << AW); i++) begin
         v          = {$urandom, $urandom};
         ref_mem[i] = v;
         rf_mem[i]  = v;
      end
      ref_mem[40] = 64'h8;
      rf_mem[40]  = 64'h8;

      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_strobes", 64'({read_en, write_en}), 64'd0);
      check("rst_address", 64'(address), 64'd0);
      check("rst_write_data", write_data, 64'd0);
      check("rst_rsp_fields", 64'({rsp_error, rsp_timeout}), 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      res = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 64'(req_ready), 64'd1);

      issue(1'b1, AW'(32), 64'h20, 0, 1'b0, 0, 1'b1);
      issue(1'b0, AW'(40), 64'h0, 2, 1'b0, 0, 1'b1);
      issue(1'b0, AW'(7), 64'h0, 1, 1'b1, 0, 1'b1);
      issue(1'b0, AW'(9), 64'h0, NO_CPL, 1'b0, 1, 1'b1);
      issue(1'b0, AW'(32), 64'h0, 0, 1'b0, 5, 1'b1);
      issue(1'b1, AW'(12), 64'hdead_beef_0123_4567, int'(TIMEOUT) - 1, 1'b0, 1, 1'b1);
      issue(1'b0, AW'(12), 64'h0, 3, 1'b0, 0, 1'b1);

      // Reset in WAIT drops the access with no response.
      issue(1'b0, AW'(5), 64'h0, NO_CPL, 1'b0, 0, 1'b0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      res = 1'b1;
      #1;
      check("mid_rst_strobes", 64'({read_en, write_en}), 64'd0);
      check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("mid_rst_address", 64'(address), 64'd0);
      check("mid_rst_req_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      res = 1'b0;
      @(negedge clk);
      check("rel_req_ready", 64'(req_ready), 64'd1);
      repeat (20) @(negedge clk);
      check("rel_no_rsp", 64'(rsp_valid), 64'd0);

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6)       dly = $urandom_range(0, TIMEOUT - 1);
         else if (r < 8)  dly = int'(TIMEOUT) - 1;
         else if (r == 8) dly = NO_CPL;
         else             dly = 0;
         issue(1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom}, dly,
               ($urandom_range(0, 4) == 0), $urandom_range(0, 3), 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
